// File: rtl/mult_if.sv
// Bus bundle for mult_control_unit: user controls, the external
// adder/subtractor loop and the product/status outputs.
//
// Handshake: run is a level request. The controller samples it only in
// IDLE and starts on the first cycle it sees it high. done is high for
// every cycle the controller sits in DONE. The user must drop run before
// the controller returns to IDLE, so one run pulse gives exactly one
// multiply. s must stay stable from the start of run until done.
interface mult_if;
  logic       run;
  logic       clear_a_load_b;
  logic [7:0] s;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_fn;
  logic [8:0] add_s;
  logic [7:0] aval;
  logic [7:0] bval;
  logic       xval;
  logic       done;
  logic [1:0] state_dbg;
  logic [2:0] cnt_dbg;

  // Controller side
  modport master (
    input  run, clear_a_load_b, s, add_s,
    output add_a, add_b, add_fn, aval, bval, xval, done, state_dbg, cnt_dbg
  );

  // User / environment side (drives requests and the adder result)
  modport slave (
    output run, clear_a_load_b, s, add_s,
    input  add_a, add_b, add_fn, aval, bval, xval, done, state_dbg, cnt_dbg
  );
endinterface

// File: rtl/mult_control_unit.sv
// mult_control_unit: 8x8 signed shift-add multiplier controller.
// {X,A,B} is an arithmetic-right-shifting accumulator. Eight iterations of
// ADD (conditional add of S, subtract on the last one for the sign bit)
// followed by SHIFT leave the signed 16-bit product in {A,B}.
//
// Optional build macro MULT_SKIP_ADD_EN: when defined, iterations whose
// multiplier bit is 0 skip the ADD state entirely, so a multiply takes
// 8 + popcount(B) cycles instead of 16. The result is identical.
module mult_control_unit (
  input  logic   clk,
  input  logic   reset,
  mult_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       x_q;
  logic [2:0] cnt_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.run) begin
`ifdef MULT_SKIP_ADD_EN
          state_d = b_q[0] ? ADD : SHIFT;
`else
          state_d = ADD;
`endif
        end
      end
      ADD:   state_d = SHIFT;
      SHIFT: begin
        if (cnt_q == 3'd7) begin
          state_d = DONE;
        end else begin
`ifdef MULT_SKIP_ADD_EN
          // b_q[1] becomes the next multiplier bit after this shift
          state_d = b_q[1] ? ADD : SHIFT;
`else
          state_d = ADD;
`endif
        end
      end
      DONE:    if (!bus.run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers A, B, X and the iteration counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      x_q   <= 1'b0;
      cnt_q <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // run wins over clear/load; B is kept so a restart reuses it
          if (bus.run) begin
            a_q   <= 8'h00;
            x_q   <= 1'b0;
            cnt_q <= 3'd0;
          end else if (bus.clear_a_load_b) begin
            a_q <= 8'h00;
            x_q <= 1'b0;
            b_q <= bus.s;
          end
        end
        ADD: begin
          if (b_q[0]) begin
            x_q <= bus.add_s[8];
            a_q <= bus.add_s[7:0];
          end
        end
        SHIFT: begin
          a_q <= {x_q, a_q[7:1]};
          b_q <= {a_q[0], b_q[7:1]};
          if (cnt_q != 3'd7) cnt_q <= cnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs; the last iteration subtracts because bit 7 carries negative weight
  always_comb begin
    bus.add_a     = a_q;
    bus.add_b     = bus.s;
    bus.add_fn    = (state_q == ADD) && (cnt_q == 3'd7);
    bus.aval      = a_q;
    bus.bval      = b_q;
    bus.xval      = x_q;
    bus.done      = (state_q == DONE);
    bus.state_dbg = state_q;
    bus.cnt_dbg   = cnt_q;
  end

endmodule

// File: tb/tb_mult_control_unit.sv
// Testbench for mult_control_unit: models the external adder, drives
// directed and random multiplies and compares against signed arithmetic.
module tb_mult_control_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [7:0] m_b;  // expected contents of register B

  mult_if bus ();

  mult_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External 9-bit sign-extended adder/subtractor
  assign bus.add_s = bus.add_fn ?
    ({bus.add_a[7], bus.add_a} - {bus.add_b[7], bus.add_b}) :
    ({bus.add_a[7], bus.add_a} + {bus.add_b[7], bus.add_b});

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  // Reference: cycles from leaving IDLE to entering DONE
  function automatic int exp_lat(input logic [7:0] b);
`ifdef MULT_SKIP_ADD_EN
    return 8 + $countones(b);
`else
    return 16;
`endif
  endfunction

  // Reference: number of cycles add_fn is high (ADD visited with cnt=7)
  function automatic int exp_fn_cnt(input logic [7:0] b);
`ifdef MULT_SKIP_ADD_EN
    return b[7] ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  // Driver: ClearA_LoadB for one cycle in IDLE
  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    bus.s = v;
    bus.run = 1'b0;
    bus.clear_a_load_b = 1'b1;
    @(negedge clk);
    bus.clear_a_load_b = 1'b0;
  endtask

  // Driver: raise run and watch until done (bounded); run stays high
  task automatic run_mult(input logic [7:0] sv, input bit with_clear, input bit noise,
                          output int lat, output int fn_cnt, output int fn_cyc);
    @(negedge clk);
    bus.s = sv;
    bus.run = 1'b1;
    bus.clear_a_load_b = with_clear;
    lat = -1;
    fn_cnt = 0;
    fn_cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      bus.clear_a_load_b = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (bus.add_fn) begin
        fn_cnt++;
        fn_cyc = n;
      end
      if (bus.done) begin
        lat = n - 1;
        break;
      end
    end
    bus.clear_a_load_b = 1'b0;
  endtask

  // Driver: drop run and let one edge pass
  task automatic release_run();
    bus.run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (bus.aval !== 8'h00) begin errors++; $display("FAIL reset_a: got %h want 00", bus.aval); end
    checks++; if (bus.bval !== 8'h00) begin errors++; $display("FAIL reset_b: got %h want 00", bus.bval); end
    checks++; if (bus.xval !== 1'b0) begin errors++; $display("FAIL reset_x: got %b want 0", bus.xval); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.add_fn !== 1'b0) begin errors++; $display("FAIL reset_add_fn: got %b want 0", bus.add_fn); end
    m_b = 8'h00;
  endtask

  task automatic test_vectors();
    logic [7:0] vb [5];
    logic [7:0] vs [5];
    logic signed [15:0] p;
    int lat, fc, fcy, el, ef;
    vb = '{8'h05, 8'h03, 8'hFF, 8'h80, 8'h00};
    vs = '{8'h07, 8'hFE, 8'hFF, 8'h80, 8'h55};
    for (int i = 0; i < 5; i++) begin
      do_load(vb[i]);
      m_b = vb[i];
      checks++; if (bus.bval !== m_b) begin errors++; $display("FAIL vec%0d_load_b: got %h want %h", i, bus.bval, m_b); end
      p  = $signed(vs[i]) * $signed(m_b);
      el = exp_lat(m_b);
      ef = exp_fn_cnt(m_b);
      run_mult(vs[i], 1'b0, 1'b0, lat, fc, fcy);
      checks++; if (lat !== el) begin errors++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, el); end
      checks++; if ({bus.aval, bus.bval} !== p) begin errors++; $display("FAIL vec%0d_product: got %h want %h", i, {bus.aval, bus.bval}, p); end
      checks++; if (bus.xval !== p[15]) begin errors++; $display("FAIL vec%0d_x: got %b want %b", i, bus.xval, p[15]); end
      checks++; if (fc !== ef) begin errors++; $display("FAIL vec%0d_add_fn_count: got %0d want %0d", i, fc, ef); end
      checks++; if (fcy !== (ef > 0 ? el - 1 : -1)) begin errors++; $display("FAIL vec%0d_add_fn_cycle: got %0d want %0d", i, fcy, (ef > 0 ? el - 1 : -1)); end
      // Hold run high: DONE must persist with values frozen
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL vec%0d_hold_done: got %b want 1", i, bus.done); end
        checks++; if ({bus.xval, bus.aval, bus.bval} !== {p[15], p}) begin errors++; $display("FAIL vec%0d_hold_value: got %h want %h", i, {bus.xval, bus.aval, bus.bval}, {p[15], p}); end
      end
      release_run();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL vec%0d_release_done: got %b want 0", i, bus.done); end
      checks++; if (bus.bval !== p[7:0]) begin errors++; $display("FAIL vec%0d_release_b: got %h want %h", i, bus.bval, p[7:0]); end
      m_b = p[7:0];
    end
  endtask

  task automatic test_priority();
    logic signed [15:0] p;
    int lat, fc, fcy;
    do_load(8'h03);
    m_b = 8'h03;
    // run and clear together: run action only, B keeps 0x03
    run_mult(8'h10, 1'b1, 1'b1, lat, fc, fcy);
    p = $signed(8'h10) * $signed(m_b);
    checks++; if ({bus.aval, bus.bval} !== p) begin errors++; $display("FAIL priority_product: got %h want %h", {bus.aval, bus.bval}, p); end
    checks++; if (lat !== exp_lat(m_b)) begin errors++; $display("FAIL priority_latency: got %0d want %0d", lat, exp_lat(m_b)); end
    release_run();
    m_b = p[7:0];
  endtask

  task automatic test_restart();
    logic signed [15:0] p;
    int lat, fc, fcy;
    // No load: the multiplier is the previous low product byte
    run_mult(8'hF9, 1'b0, 1'b0, lat, fc, fcy);
    p = $signed(8'hF9) * $signed(m_b);
    checks++; if ({bus.xval, bus.aval, bus.bval} !== {p[15], p}) begin errors++; $display("FAIL restart_product: got %h want %h", {bus.xval, bus.aval, bus.bval}, {p[15], p}); end
    checks++; if (lat !== exp_lat(m_b)) begin errors++; $display("FAIL restart_latency: got %0d want %0d", lat, exp_lat(m_b)); end
    release_run();
    m_b = p[7:0];
  endtask

  task automatic test_mid_reset();
    bit hit;
    int lat, fc, fcy;
    do_load(8'h6B);
    @(negedge clk);
    bus.s = 8'h3C;
    bus.run = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(negedge clk);
      if (bus.state_dbg == 2'd2 && bus.cnt_dbg == 3'd3) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL midreset_reach_shift3: got 0 want 1"); end
    #2 reset = 1'b1;
    bus.run = 1'b0;
    #1;
    checks++; if ({bus.aval, bus.bval} !== 16'h0000) begin errors++; $display("FAIL midreset_ab: got %h want 0000", {bus.aval, bus.bval}); end
    checks++; if (bus.xval !== 1'b0) begin errors++; $display("FAIL midreset_x: got %b want 0", bus.xval); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", bus.done); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL midreset_idle: got %0d want 0", bus.state_dbg); end
    m_b = 8'h00;
    run_mult(8'h55, 1'b0, 1'b0, lat, fc, fcy);
    checks++; if ({bus.aval, bus.bval} !== 16'h0000) begin errors++; $display("FAIL midreset_rerun_product: got %h want 0000", {bus.aval, bus.bval}); end
    checks++; if (lat !== exp_lat(8'h00)) begin errors++; $display("FAIL midreset_rerun_latency: got %0d want %0d", lat, exp_lat(8'h00)); end
    release_run();
  endtask

  task automatic test_random();
    logic signed [15:0] p;
    logic [7:0] sv;
    int lat, fc, fcy;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        m_b = 8'($urandom_range(0, 255));
        do_load(m_b);
      end
      sv = 8'($urandom_range(0, 255));
      p = $signed(sv) * $signed(m_b);
      run_mult(sv, 1'($urandom_range(0, 1)), 1'b1, lat, fc, fcy);
      checks++; if (lat !== exp_lat(m_b)) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_lat(m_b)); end
      checks++; if ({bus.xval, bus.aval, bus.bval} !== {p[15], p}) begin errors++; $display("FAIL rnd%0d_product: b=%h s=%h got %h want %h", i, m_b, sv, {bus.xval, bus.aval, bus.bval}, {p[15], p}); end
      checks++; if (fc !== exp_fn_cnt(m_b)) begin errors++; $display("FAIL rnd%0d_add_fn_count: got %0d want %0d", i, fc, exp_fn_cnt(m_b)); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_run();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rnd%0d_release_done: got %b want 0", i, bus.done); end
      m_b = p[7:0];
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.run = 1'b0;
    bus.clear_a_load_b = 1'b0;
    bus.s = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_vectors();
    test_priority();
    test_restart();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_control_unit.md
MULT_CONTROL_UNIT -- requirements
Module: mult_control_unit

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 Run  input  1  start request; level-sampled in IDLE, release required in DONE.
REQ-004 ClearA_LoadB  input  1  in IDLE: A<=0, X<=0, B<=S.
REQ-005 S  input  8  signed multiplicand / load value.
REQ-006 add_a  output  8  adder operand A, equal to register A.
REQ-007 add_b  output  8  adder operand B, equal to S.
REQ-008 add_fn  output  1  adder mode: 0 add, 1 subtract.
REQ-009 add_s  input  9  9-bit sign-extended result from the external adder/subtractor, combinational from add_a/add_b/add_fn.
REQ-010 Aval  output  8  register A, upper product byte.
REQ-011 Bval  output  8  register B, multiplier and then lower product byte.
REQ-012 Xval  output  1  register X, sign-extension bit.
REQ-013 done  output  1  high while in DONE.

Function
REQ-014 States SHALL be IDLE, ADD, SHIFT, DONE, plus a 3-bit iteration counter cnt (0..7).
REQ-015 IDLE with Run=1 SHALL clear A and X, set cnt=0, and go to ADD next cycle; B keeps its value.
REQ-016 IDLE with Run=0 and ClearA_LoadB=1 SHALL load A=0, X=0, B=S; ClearA_LoadB SHALL be ignored in all other states.
REQ-017 IDLE with both Run and ClearA_LoadB high SHALL take the Run action only.
REQ-018 add_fn SHALL be 1 only in ADD with cnt=7, else 0.
REQ-019 ADD with B[0]=1 SHALL capture X<=add_s[8], A<=add_s[7:0]; with B[0]=0, A and X SHALL hold; next state SHIFT.
REQ-020 SHIFT SHALL do A<={X,A[7:1]}, B<={A[0],B[7:1]}, X unchanged (arithmetic right shift of {X,A,B}).
REQ-021 SHIFT with cnt<7 SHALL increment cnt and go to ADD; with cnt=7 it SHALL go to DONE.
REQ-022 Baseline latency: exactly 16 cycles from leaving IDLE to entering DONE; {A,B} then holds the signed 16-bit product of S and the original B.
REQ-023 S SHALL be held stable by the user from Run assertion to DONE; behaviour on S change mid-operation is undefined.
REQ-024 DONE SHALL hold A, B, X while Run=1 and return to IDLE on the first cycle with Run=0; no restart without Run release.
REQ-025 A restart from IDLE SHALL use the current B (previous low product byte) as multiplier.

Reset
REQ-026 Reset=1 SHALL asynchronously force IDLE, cnt=0, A=0x00, B=0x00, X=0, done=0, add_fn=0, regardless of state.
REQ-027 Reset released mid-operation SHALL leave the block in IDLE with no residual operation.

Configuration
REQ-028 Macro MULT_SKIP_ADD_EN: when defined, ADD SHALL be bypassed for iterations whose B[0]=0 (state goes directly to SHIFT), giving latency 8 + popcount(original B) cycles; when undefined, every iteration visits ADD (16 cycles); final {X,A,B} identical in both builds.

Verification
REQ-029 ClearA_LoadB with S=0x05, then S=0x07, Run -> after 16 cycles done=1, A=0x00, B=0x23, X=0.
REQ-030 Load B=0x03, S=0xFE, Run -> A=0xFF, B=0xFA, X=1 (-6).
REQ-031 Load B=0xFF, S=0xFF, Run -> A=0x00, B=0x01, X=0; add_fn=1 observed only in the 15th cycle after leaving IDLE (ADD, cnt=7).
REQ-032 Load B=0x80, S=0x80, Run -> A=0x40, B=0x00, X=0; Run held high 5 extra cycles -> state stays DONE, values unchanged.
REQ-033 Reset pulsed during SHIFT of cnt=3 -> A=B=0x00, X=0, done=0 immediately; next Run with B=0, S=0x55 yields A=0x00, B=0x00.
REQ-034 With MULT_SKIP_ADD_EN, load B=0x00, S=0x55, Run -> done after 8 cycles, A=B=0x00; without the macro the same stimulus gives done after 16 cycles.
